// File: rtl/hsv_core_pkg.sv
// Shared types and defaults for the core flush sequencer.
package hsv_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        HOLD  = 2'd2,
        EXIT  = 2'd3
    } flush_state_t;

    // Default number of execution units taking part in a flush.
    localparam int HSV_N_EXEC_UNITS = 6;

    // States in which the broadcast request is asserted.
    function automatic logic is_req_state(input flush_state_t s);
        return (s == ENTER) || (s == HOLD);
    endfunction

    // Watchdog counter width: at least 8 bits, wider for large limits.
    function automatic int wd_cnt_width(input int limit);
        return (limit > 255) ? $clog2(limit + 1) : 8;
    endfunction

endpackage

// File: rtl/hsv_core_flush_watchdog.sv
// Flush watchdog: counts cycles spent waiting for acks in ENTER/EXIT and
// records which units were lagging when the limit is reached. The flag is
// sticky until reset; the FSM is never forced out of its wait.
module hsv_core_flush_watchdog
    import hsv_core_pkg::*;
#(
    parameter int N_UNITS        = HSV_N_EXEC_UNITS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_core,
    input  logic               rst_core_n,
    input  flush_state_t       state,
    input  flush_state_t       state_next,
    input  logic [N_UNITS-1:0] flush_ack,
    output logic               timeout,
    output logic [N_UNITS-1:0] stuck_mask
);

    localparam int                CNT_W   = wd_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  FIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               timeout_reg;
    logic [N_UNITS-1:0] mask_reg;
    logic [N_UNITS-1:0] lagging;
    logic               waiting;
    logic               staying;
    logic               fire;

    assign waiting = (state == ENTER) || (state == EXIT);
    assign staying = (state_next == state);
    // The limit is reached on the edge where the counter would step onto it.
    assign fire    = waiting && staying && (cnt_reg == FIRE_AT);

    // A unit lags if it has not yet followed req: still 0 in ENTER, still 1 in EXIT.
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_lag
        assign lagging[gi] = (state == ENTER) ? ~flush_ack[gi] : flush_ack[gi];
    end

    // Counter clears on any state change and saturates so each wait fires once.
    always_comb begin
        cnt_next = cnt_reg;
        if (!waiting || !staying) begin
            cnt_next = '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Counter, sticky flag and lagging-unit capture.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
            mask_reg    <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (fire) begin
                timeout_reg <= 1'b1;
                mask_reg    <= lagging;
            end
        end
    end

    assign timeout    = timeout_reg;
    assign stuck_mask = mask_reg;

endmodule

// File: rtl/hsv_core_flush_ctrl.sv
// Core-wide flush req/ack sequencer. Broadcasts flush_req, collects every
// unit's flush_ack and enforces the IDLE->ENTER->HOLD->EXIT ordering.
// Reset lands in ENTER so the pipeline is flushed after every reset.
// Optional watchdog: define HSV_CORE_FLUSH_TIMEOUT_EN.
module hsv_core_flush_ctrl
    import hsv_core_pkg::*;
#(
    parameter int N_UNITS        = HSV_N_EXEC_UNITS,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_core,
    input  logic               rst_core_n,
    input  logic               start_i,
    output logic               flush_req,
    input  logic [N_UNITS-1:0] flush_ack,
    output logic               busy_o,
    output logic               done_o,
    output logic               flush_timeout_o,
    output logic [N_UNITS-1:0] stuck_mask_o
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    flush_state_t state_reg;
    flush_state_t state_next;
    logic [7:0]   hold_reg;
    logic [7:0]   hold_next;
    logic         pending_reg;
    logic         pending_next;
    logic         req_reg;
    logic         busy_reg;
    logic         done_reg;

    // Next-state logic; acks are only looked at while waiting in ENTER/EXIT.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                if (start_i || pending_reg) begin
                    state_next   = ENTER;
                    pending_next = 1'b0;
                end
            end
            ENTER: begin
                // start_i here is absorbed by the flush already running.
                if (&flush_ack) begin
                    state_next = HOLD;
                    hold_next  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_reg == 8'd0) begin
                    state_next = EXIT;
                end else begin
                    hold_next = hold_reg - 8'd1;
                end
            end
            EXIT: begin
                // A request arriving while exiting is remembered, not dropped.
                if (start_i) begin
                    pending_next = 1'b1;
                end
                if (~|flush_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = ENTER;
        endcase
    end

    // State and registered outputs; all outputs come straight from flops.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_reg   <= ENTER;
            hold_reg    <= '0;
            pending_reg <= 1'b0;
            req_reg     <= 1'b1;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            pending_reg <= pending_next;
            req_reg     <= is_req_state(state_next);
            busy_reg    <= (state_next != IDLE);
            done_reg    <= (state_reg == EXIT) && (state_next == IDLE);
        end
    end

    assign flush_req = req_reg;
    assign busy_o    = busy_reg;
    assign done_o    = done_reg;

`ifdef HSV_CORE_FLUSH_TIMEOUT_EN
    hsv_core_flush_watchdog #(
        .N_UNITS        (N_UNITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .state      (state_reg),
        .state_next (state_next),
        .flush_ack  (flush_ack),
        .timeout    (flush_timeout_o),
        .stuck_mask (stuck_mask_o)
    );
`else
    assign flush_timeout_o = 1'b0;
    assign stuck_mask_o    = '0;
`endif

endmodule
